// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC and fetch control (optional PC_MISALIGN_TRAP_EN)
module pc_sequencer #(
    parameter int unsigned PC_INC = 4,
    parameter int unsigned WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] pco,
    input  logic              ihit,
    input  logic              stall,
    input  logic              branch_take,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump_en,
    input  logic [WORD_W-1:0] jump_target,
    input  logic              halt_req,
    output logic              WEN,
    output logic [WORD_W-1:0] pci,
    output logic              halt,
    output logic              imemREN,
    output logic              instr_valid,
    output logic              misalign
);

    typedef enum logic [1:0] {BOOT, FETCH, HALTED} state_t;

    state_t             state, state_n;
    logic               pending_v, pending_v_n;
    logic [WORD_W-1:0]  pending_tgt, pending_tgt_n;
    logic               redir;
    logic [WORD_W-1:0]  tgt;
    logic               wen_raw;
    logic [WORD_W-1:0]  pci_raw;
    logic               ren_raw;
    logic               valid_raw;
    logic               wen_fin;
    logic [WORD_W-1:0]  pci_fin;
`ifdef PC_MISALIGN_TRAP_EN
    logic               misalign_q;
    logic               trap;
`endif

    assign redir = branch_take | jump_en;
    assign tgt   = branch_take ? branch_target : jump_target;

    // State and pending-redirect registers; reset drops any held redirect
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= BOOT;
            pending_v   <= 1'b0;
            pending_tgt <= '0;
        end else begin
            state       <= state_n;
            pending_v   <= pending_v_n;
            pending_tgt <= pending_tgt_n;
        end
    end

    // Fetch arbitration: redirect > pending apply > halt > sequential > wait
    always_comb begin
        state_n       = state;
        pending_v_n   = pending_v;
        pending_tgt_n = pending_tgt;
        wen_raw       = 1'b0;
        pci_raw       = '0;
        ren_raw       = 1'b0;
        valid_raw     = 1'b0;
        case (state)
            BOOT: state_n = FETCH;
            FETCH: begin
                ren_raw = 1'b1;
                if (redir && ihit) begin
                    wen_raw     = 1'b1;
                    pci_raw     = tgt;
                    pending_v_n = 1'b0;
                end else if (redir) begin
                    pending_v_n   = 1'b1;
                    pending_tgt_n = tgt;
                end else if (pending_v && ihit) begin
                    wen_raw     = 1'b1;
                    pci_raw     = pending_tgt;
                    pending_v_n = 1'b0;
                end else if (halt_req && !pending_v) begin
                    state_n = HALTED;
                end else if (ihit && !stall) begin
                    wen_raw   = 1'b1;
                    pci_raw   = pco + WORD_W'(PC_INC);
                    valid_raw = 1'b1;
                end
            end
            default: state_n = HALTED;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        trap = wen_raw && (pci_raw[1:0] != 2'b00);
        if (trap) begin
            state_n     = HALTED;
            pending_v_n = 1'b0;
        end
        wen_fin = wen_raw && !trap;
        pci_fin = trap ? '0 : pci_raw;
`else
        wen_fin = wen_raw;
        pci_fin = pci_raw;
`endif
    end

`ifdef PC_MISALIGN_TRAP_EN
    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge CLK) begin
        if (!nRST)
            misalign_q <= 1'b0;
        else if (trap)
            misalign_q <= 1'b1;
    end
    assign misalign = nRST & misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // Outputs are forced low while reset is held
    always_comb begin
        WEN         = nRST & wen_fin;
        pci         = nRST ? pci_fin : '0;
        imemREN     = nRST & ren_raw;
        instr_valid = nRST & valid_raw;
        halt        = nRST & (state == HALTED);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] pco = 32'h0;
    logic        ihit, stall, branch_take, jump_en, halt_req;
    logic [31:0] branch_target, jump_target;
    logic        WEN, halt, imemREN, instr_valid, misalign;
    logic [31:0] pci;

    typedef struct {
        string       tag;
        logic [36:0] val;
    } sb_t;

    sb_t sb[$];
    int  tests  = 0;
    int  failed = 0;

    pc_sequencer #(.PC_INC(4), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .pco(pco), .ihit(ihit), .stall(stall),
        .branch_take(branch_take), .branch_target(branch_target),
        .jump_en(jump_en), .jump_target(jump_target), .halt_req(halt_req),
        .WEN(WEN), .pci(pci), .halt(halt), .imemREN(imemREN),
        .instr_valid(instr_valid), .misalign(misalign)
    );

    always #5 CLK = ~CLK;

    // PC block model: loads pci when WEN, untouched by reset
    always @(posedge CLK) if (WEN) pco <= pci;

    task automatic idle();
        ihit = 0; stall = 0; branch_take = 0; jump_en = 0; halt_req = 0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    task automatic step_expect(input string tag, input logic w, input logic [31:0] p,
                               input logic h, input logic r, input logic v, input logic m);
        sb_t e;
        sb_t got;
        logic [36:0] obs;
        sb.push_back('{tag, {w, p, h, r, v, m}});
        @(negedge CLK);
        got = sb.pop_front();
        obs = {WEN, pci, halt, imemREN, instr_valid, misalign};
        tests++;
        assert (obs === got.val) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", got.tag, obs, got.val);
        end
        @(posedge CLK);
        #1;
        e = got;
    endtask

    initial begin
        idle();
        nRST = 0;
        #1;
        step_expect("reset0", 0, 32'h0, 0, 0, 0, 0);
        step_expect("reset1", 0, 32'h0, 0, 0, 0, 0);
        nRST = 1;
        step_expect("boot", 0, 32'h0, 0, 0, 0, 0);
        ihit = 1;
        step_expect("seq0", 1, 32'h4, 0, 1, 1, 0);
        step_expect("seq4", 1, 32'h8, 0, 1, 1, 0);
        ihit = 0;
        step_expect("wait0", 0, 32'h0, 0, 1, 0, 0);
        step_expect("wait1", 0, 32'h0, 0, 1, 0, 0);
        step_expect("wait2", 0, 32'h0, 0, 1, 0, 0);
        ihit = 1; stall = 1;
        step_expect("stall", 0, 32'h0, 0, 1, 0, 0);
        stall = 0;
        step_expect("unstall", 1, 32'hC, 0, 1, 1, 0);
        ihit = 0; jump_en = 1; jump_target = 32'h100;
        step_expect("jmp_wait", 0, 32'h0, 0, 1, 0, 0);
        jump_en = 0; halt_req = 1;
        step_expect("halt_wrongpath", 0, 32'h0, 0, 1, 0, 0);
        halt_req = 0; ihit = 1;
        step_expect("pend_apply", 1, 32'h100, 0, 1, 0, 0);
        step_expect("seq100", 1, 32'h104, 0, 1, 1, 0);
        branch_take = 1; branch_target = 32'h200;
        jump_en = 1; jump_target = 32'h300; stall = 1;
        step_expect("priority", 1, 32'h200, 0, 1, 0, 0);
        idle();
        jump_en = 1; jump_target = 32'h400;
        step_expect("ovw_a", 0, 32'h0, 0, 1, 0, 0);
        jump_en = 0; branch_take = 1; branch_target = 32'h500;
        step_expect("ovw_b", 0, 32'h0, 0, 1, 0, 0);
        branch_take = 0; ihit = 1;
        step_expect("ovw_apply", 1, 32'h500, 0, 1, 0, 0);
        jump_en = 1; jump_target = 32'hFFFF_FFFC;
        step_expect("jmp_top", 1, 32'hFFFF_FFFC, 0, 1, 0, 0);
        jump_en = 0;
        step_expect("wrap", 1, 32'h0, 0, 1, 1, 0);
        halt_req = 1;
        step_expect("halt_req", 0, 32'h0, 0, 1, 0, 0);
        halt_req = 0; jump_en = 1; jump_target = 32'h40;
        step_expect("halted_jmp", 0, 32'h0, 1, 0, 0, 0);
        jump_en = 0; branch_take = 1; branch_target = 32'h80;
        step_expect("halted_br", 0, 32'h0, 1, 0, 0, 0);
        idle();
        nRST = 0;
        step_expect("rst_halt", 0, 32'h0, 0, 0, 0, 0);
        nRST = 1;
        step_expect("reboot", 0, 32'h0, 0, 0, 0, 0);
        ihit = 1;
        step_expect("seq_after", 1, 32'h4, 0, 1, 1, 0);
        branch_take = 1; branch_target = 32'h102;
`ifdef PC_MISALIGN_TRAP_EN
        step_expect("mis_br", 0, 32'h0, 0, 1, 0, 0);
        idle();
        step_expect("mis_trap", 0, 32'h0, 1, 0, 0, 1);
        ihit = 1;
        step_expect("mis_sticky", 0, 32'h0, 1, 0, 0, 1);
`else
        step_expect("mis_br", 1, 32'h102, 0, 1, 0, 0);
        idle();
        step_expect("mis_none", 0, 32'h0, 0, 1, 0, 0);
        ihit = 1;
        step_expect("mis_seq", 1, 32'h106, 0, 1, 1, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC and fetch-control unit that drives the program counter's write side.
- It samples the current PC value and produces the PC write-enable, next-PC value and halt to the PC block.
- It arbitrates sequential fetch, branch/jump redirects, hazard stalls, instruction-memory wait states and processor halt.
- Sits between the instruction-memory request path and the PC block, one per datapath.

Parameters:
- PC_INC, 4: byte increment for sequential fetch.
- WORD_W, 32: PC width; matches word_t.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset.
- pco  input  WORD_W  current PC from the PC block.
- ihit  input  1  instruction memory returned the word at pco this cycle.
- stall  input  1  hazard stall from decode; hold PC.
- branch_take  input  1  resolved taken branch (execute stage).
- branch_target  input  WORD_W  branch destination.
- jump_en  input  1  jump/jr from decode.
- jump_target  input  WORD_W  jump destination.
- halt_req  input  1  halt instruction decoded.
- WEN  output  1  PC write enable.
- pci  output  WORD_W  next PC value; meaningful when WEN=1.
- halt  output  1  sticky processor halt, also to the PC block.
- imemREN  output  1  instruction fetch request.
- instr_valid  output  1  fetched word is on the correct path and consumed this cycle.
- misalign  output  1  see Optional Feature.

Behaviour:
- Reset: nRST is sampled at the CLK edge. While low, state=BOOT, pending_v=0, pending_tgt=0. All outputs are 0 (WEN, pci, halt, imemREN, instr_valid, misalign).
- Reset mid-operation discards any pending redirect and clears HALTED. It does not touch the PC register.
- States: BOOT, FETCH, HALTED.
- BOOT: one cycle after nRST rises. imemREN=0, WEN=0. Next state is FETCH.
- FETCH: imemREN=1. Definitions: redir = branch_take | jump_en. tgt = branch_target if branch_take, else jump_target. Branch has priority over jump.
- Outputs in FETCH are combinational and evaluated in this priority order:
  1. redir & ihit: WEN=1, pci=tgt, instr_valid=0, pending_v cleared.
  2. redir & !ihit: WEN=0. Next cycle pending_v=1, pending_tgt=tgt. A new redirect overwrites an existing pending target.
  3. pending_v & ihit: WEN=1, pci=pending_tgt, instr_valid=0 (wrong-path word dropped). pending_v cleared next cycle.
  4. halt_req & !pending_v: WEN=0, instr_valid=0. Next state HALTED.
  5. ihit & !stall: WEN=1, pci=pco+PC_INC (mod 2^WORD_W, wrap silently), instr_valid=1.
  6. Otherwise (waiting on ihit, or stalled): WEN=0, instr_valid=0.
- Redirect overrides stall and halt_req in the same cycle. halt_req while pending_v=1 is ignored because it comes from the wrong path.
- Latency:
  - Sequential: pci is valid in the same cycle as ihit. The PC updates at the next edge.
  - Redirect with ihit: PC equals the target one edge later.
  - Redirect without ihit: the target is held until the first ihit, then applied at that edge.
- HALTED: halt=1 (registered, sticky), imemREN=0, WEN=0, instr_valid=0. All inputs are ignored until nRST.
- pending_v is set only in FETCH.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Any WEN=1 cycle whose pci[1:0] != 0 is suppressed to WEN=0.
  - misalign is set (registered, sticky) and the state goes to HALTED next cycle, with halt=1.
  - A misaligned target sitting in pending is checked when it is applied.
- Not defined:
  - pci passes through unmodified.
  - misalign is tied to 0.
  - No extra logic.

Test Plan:
- Reset then sequential fetch: nRST low 2 cycles, then high. Sequence is BOOT 1 cycle, then FETCH with imemREN=1. pco=0x0 with ihit=1 gives WEN=1, pci=0x4, instr_valid=1. pco=0x4 gives pci=0x8.
- Memory wait and stall: ihit=0 for 3 cycles gives WEN=0, imemREN=1. stall=1 with ihit=1 gives WEN=0, instr_valid=0. Releasing stall gives WEN=1, pci=pco+4.
- Redirect during wait: jump_en=1, jump_target=0x100 with ihit=0 gives WEN=0. Next ihit gives WEN=1, pci=0x100, instr_valid=0.
- Priority: branch_take=1 (0x200), jump_en=1 (0x300) and stall=1 together with ihit=1 give WEN=1, pci=0x200.
- Halt: halt_req=1 with ihit=1 and no redirect gives halt=1 from the next cycle and imemREN=0. Later ihit, jump_en and branch_take pulses give WEN=0. nRST low for 1 cycle then high clears halt, followed by BOOT then FETCH.
- With PC_MISALIGN_TRAP_EN: branch_take=1, branch_target=0x102, ihit=1 gives WEN=0, then misalign=1 and halt=1 next cycle. Without the macro, the same stimulus gives WEN=1, pci=0x102, misalign=0.
